// File: rtl/frame_queue_pkg.sv
// Shared definitions for the frame queue producers and the source arbiter:
// marker words, source ids, arbitration modes and arbiter states.
package frame_queue_pkg;

    localparam logic [16:0] MARK_SOF = 17'h10000;
    localparam logic [16:0] MARK_SOL = 17'h10001;
    localparam logic [16:0] MARK_EOF = 17'h1FFFF;

    typedef enum logic {
        SRC_CAMERA  = 1'b0,
        SRC_PATTERN = 1'b1
    } frame_src_t;

    typedef enum logic [1:0] {
        MODE_CAMERA   = 2'd0,
        MODE_PATTERN  = 2'd1,
        MODE_AUTO     = 2'd2,
        MODE_AUTO_ALT = 2'd3
    } arb_mode_t;

    typedef enum logic [1:0] {
        ST_WAIT_SOF   = 2'd0,
        ST_IN_FRAME   = 2'd1,
        ST_INJECT_EOF = 2'd2
    } arb_state_t;

endpackage

// File: rtl/frame_watchdog.sv
// Camera liveness watchdog: counts cycles since the last camera SOF strobe,
// saturating at WATCHDOG_CYCLES; the camera is alive while below the limit.
module frame_watchdog
    import frame_queue_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cam_wr_en,
    input  logic [16:0] cam_data,
    output logic        alive
);

    localparam int unsigned CW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WATCHDOG_CYCLES);

    logic [CW-1:0] count;
    logic          sof_seen;

    assign sof_seen = cam_wr_en && (cam_data == MARK_SOF);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff reads the pre-edge value of every register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= LIMIT;
        end else if (sof_seen) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    assign alive = (count < LIMIT);

endmodule

// File: rtl/frame_source_arbiter.sv
// Grants the frame queue to the camera or the pattern generator, switching
// only between frames and closing stalled camera frames with an injected EOF.
module frame_source_arbiter
    import frame_queue_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = 1_000_000,
    parameter logic [1:0]  HOLD_MASK       = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic [16:0] cam_data,
    input  logic        cam_wr_en,
    output logic        cam_full,
    input  logic [16:0] pat_data,
    input  logic        pat_wr_en,
    output logic        pat_full,
    input  logic        queue_full,
    output logic [16:0] queue_data,
    output logic        queue_wr_en,
    output logic        queue_wr_clk,
    output logic        active_src,
    output logic        camera_alive,
    output logic [15:0] frames_done,
    output logic [7:0]  frames_truncated
);

    arb_state_t  state_q, state_d;
    frame_src_t  src_q, src_d, desired;
    logic        is_auto;
    logic [16:0] g_data;
    logic        g_wr_en, g_accept;
    logic        fwd, inject, grant_full, done_inc, trunc_inc;

    frame_watchdog #(
        .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .cam_wr_en(cam_wr_en),
        .cam_data (cam_data),
        .alive    (camera_alive)
    );

    assign queue_wr_clk = clk;
    assign active_src   = src_q;
    assign is_auto      = mode[1];

    always_comb begin
        case (arb_mode_t'(mode))
            MODE_CAMERA:  desired = SRC_CAMERA;
            MODE_PATTERN: desired = SRC_PATTERN;
            default:      desired = camera_alive ? SRC_CAMERA : SRC_PATTERN;
        endcase
    end

    assign g_data   = (src_q == SRC_PATTERN) ? pat_data  : cam_data;
    assign g_wr_en  = (src_q == SRC_PATTERN) ? pat_wr_en : cam_wr_en;
    assign g_accept = g_wr_en && !queue_full;

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        fwd        = 1'b0;
        inject     = 1'b0;
        grant_full = 1'b0;
        done_inc   = 1'b0;
        trunc_inc  = 1'b0;
        case (state_q)
            ST_WAIT_SOF: begin
                // A grant change burns this cycle; otherwise hunt for SOF.
                if (desired != src_q) begin
                    src_d = desired;
                end else if (g_accept && (g_data == MARK_SOF)) begin
                    fwd     = 1'b1;
                    state_d = ST_IN_FRAME;
                end
            end
            ST_IN_FRAME: begin
                grant_full = queue_full;
                if ((src_q == SRC_CAMERA) && is_auto && !camera_alive) begin
                    state_d = ST_INJECT_EOF;
                end else begin
                    fwd = g_wr_en;
                    if (g_accept && (g_data == MARK_EOF)) begin
                        state_d  = ST_WAIT_SOF;
                        done_inc = 1'b1;
                    end
                end
            end
            ST_INJECT_EOF: begin
                inject = 1'b1;
                if (!queue_full) begin
                    trunc_inc = 1'b1;
                    state_d   = ST_WAIT_SOF;
                end
            end
            default: state_d = ST_WAIT_SOF;
        endcase
    end

    assign queue_wr_en = inject | fwd;
    assign queue_data  = inject ? MARK_EOF : (fwd ? g_data : 17'h0);
    assign cam_full    = (src_q == SRC_CAMERA)  ? grant_full : HOLD_MASK[0];
    assign pat_full    = (src_q == SRC_PATTERN) ? grant_full : HOLD_MASK[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_WAIT_SOF;
            src_q            <= SRC_CAMERA;
            frames_done      <= 16'd0;
            frames_truncated <= 8'd0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            frames_done <= frames_done + 16'(done_inc);
            if (trunc_inc && (frames_truncated != 8'hFF)) begin
                frames_truncated <= frames_truncated + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_source_arbiter.sv
// Directed bench for frame_source_arbiter: stimulus pushes the words it expects
// on the queue port, a negedge monitor pops and compares every accepted write.
module tb_frame_source_arbiter;
    import frame_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset, cam_wr_en, pat_wr_en, queue_full;
    logic [1:0]  mode;
    logic [16:0] cam_data, pat_data;
    logic        cam_full, pat_full, queue_wr_en, queue_wr_clk;
    logic        active_src, camera_alive;
    logic [16:0] queue_data;
    logic [15:0] frames_done;
    logic [7:0]  frames_truncated;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_exp;
    logic        cam_full_s, pat_full_s;

    frame_source_arbiter #(
        .WATCHDOG_CYCLES(100),
        .HOLD_MASK      (2'b10)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mode            (mode),
        .cam_data        (cam_data),
        .cam_wr_en       (cam_wr_en),
        .cam_full        (cam_full),
        .pat_data        (pat_data),
        .pat_wr_en       (pat_wr_en),
        .pat_full        (pat_full),
        .queue_full      (queue_full),
        .queue_data      (queue_data),
        .queue_wr_en     (queue_wr_en),
        .queue_wr_clk    (queue_wr_clk),
        .active_src      (active_src),
        .camera_alive    (camera_alive),
        .frames_done     (frames_done),
        .frames_truncated(frames_truncated)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample back-pressure mid-cycle, return just after the edge.
    task automatic step();
        @(negedge clk);
        cam_full_s = cam_full;
        pat_full_s = pat_full;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] word1(input int k);
        if (k == 0)   return MARK_SOF;
        if (k == 1)   return MARK_SOL;
        if (k == 482) return MARK_EOF;
        return 17'(k - 2);
    endfunction

    always @(negedge clk) begin
        if (queue_wr_en === 1'b1 && queue_full === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL unexpected_write: got %h expected no write", queue_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("queue_word", 32'(queue_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    initial begin
        int err;
        int idx;
        int cyc;
        logic [16:0] frame4 [32];

        reset = 1'b1; mode = 2'd1; queue_full = 1'b0;
        cam_wr_en = 1'b0; cam_data = '0; pat_wr_en = 1'b0; pat_data = '0;
        step(); step();
        check("rst_active_src", 32'(active_src), 32'd0);
        check("rst_camera_alive", 32'(camera_alive), 32'd0);
        check("rst_frames_done", 32'(frames_done), 32'd0);
        check("rst_frames_truncated", 32'(frames_truncated), 32'd0);
        check("rst_queue_wr_en", 32'(queue_wr_en), 32'd0);
        check("rst_queue_data", 32'(queue_data), 32'd0);
        check("rst_pat_full_held", 32'(pat_full_s), 32'd1);

        // Forced pattern: one full 483-word frame.
        reset = 1'b0;
        step();
        check("t1_grant_pattern", 32'(active_src), 32'd1);
        for (int k = 0; k < 483; k++) exp_q.push_back(word1(k));
        err = 0;
        for (int k = 0; k < 483; k++) begin
            pat_wr_en = 1'b1; pat_data = word1(k);
            step();
            if (cam_full_s !== 1'b0) err++;
        end
        pat_wr_en = 1'b0;
        check("t1_frames_done", 32'(frames_done), 32'd1);
        check("t1_cam_full_low", 32'(err), 32'd0);

        // Auto mode: camera comes alive while the pattern is mid-frame.
        mode = 2'd2;
        exp_q.push_back(MARK_SOF);
        for (int k = 1; k < 11; k++) exp_q.push_back(17'h00200 + 17'(k));
        exp_q.push_back(MARK_EOF);
        err = 0;
        for (int k = 0; k < 12; k++) begin
            pat_wr_en = 1'b1;
            pat_data  = (k == 0) ? MARK_SOF : ((k == 11) ? MARK_EOF : 17'h00200 + 17'(k));
            cam_wr_en = 1'b1;
            cam_data  = (k == 0) ? MARK_SOF : 17'h00050 + 17'(k);
            step();
            if (cam_full_s !== 1'b0 || pat_full_s !== 1'b0) err++;
        end
        check("t2_full_flags", 32'(err), 32'd0);
        check("t2_frames_done", 32'(frames_done), 32'd2);
        check("t2_grant_held_to_eof", 32'(active_src), 32'd1);
        pat_wr_en = 1'b0; cam_data = 17'h00060;
        step();
        check("t2_grant_camera", 32'(active_src), 32'd0);
        err = 0;
        for (int k = 0; k < 3; k++) begin
            cam_data = 17'h00070 + 17'(k);
            pat_wr_en = 1'b1; pat_data = 17'h00777;
            step();
            if (cam_full_s !== 1'b0 || pat_full_s !== 1'b1) err++;
        end
        check("t2_discard_flags", 32'(err), 32'd0);
        pat_wr_en = 1'b0;
        exp_q.push_back(MARK_SOF);
        cam_data = MARK_SOF;
        step();

        // Camera stalls mid-frame: EOF injected after 100 quiet cycles.
        exp_q.push_back(MARK_SOL);
        for (int k = 0; k < 5; k++) exp_q.push_back(17'h00300 + 17'(k));
        exp_q.push_back(MARK_EOF);
        cam_data = MARK_SOL;
        step();
        for (int k = 0; k < 5; k++) begin
            cam_data = 17'h00300 + 17'(k);
            step();
        end
        cam_wr_en = 1'b0;
        repeat (93) step();
        check("t3_alive_before_expiry", 32'(camera_alive), 32'd1);
        step();
        check("t3_alive_expired", 32'(camera_alive), 32'd0);
        check("t3_no_forward_on_expiry", 32'(queue_wr_en), 32'd0);
        step();
        check("t3_inject_wr_en", 32'(queue_wr_en), 32'd1);
        check("t3_inject_data", 32'(queue_data), 32'(MARK_EOF));
        step();
        check("t3_frames_truncated", 32'(frames_truncated), 32'd1);
        check("t3_grant_still_camera", 32'(active_src), 32'd0);
        step();
        check("t3_grant_pattern", 32'(active_src), 32'd1);
        exp_q.push_back(MARK_SOF);
        pat_wr_en = 1'b1; pat_data = MARK_SOF;
        step();

        // Back-pressure: queue full for 20 cycles, pattern holds its word.
        frame4[0]  = MARK_SOL;
        for (int k = 1; k < 31; k++) frame4[k] = 17'h00400 + 17'(k);
        frame4[31] = MARK_EOF;
        for (int k = 0; k < 32; k++) exp_q.push_back(frame4[k]);
        err = 0; idx = 0; cyc = 0;
        while (idx < 32 && cyc < 200) begin
            queue_full = (cyc >= 5 && cyc < 25);
            pat_wr_en  = 1'b1;
            pat_data   = frame4[idx];
            @(negedge clk);
            if (pat_full !== queue_full) err++;
            if (pat_full === 1'b0) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        pat_wr_en = 1'b0; queue_full = 1'b0;
        check("t4_all_words_sent", 32'(idx), 32'd32);
        check("t4_pat_full_tracks_queue", 32'(err), 32'd0);
        check("t4_frames_done", 32'(frames_done), 32'd3);
        check("t4_words_drained", 32'(exp_q.size()), 32'd0);

        // Injected EOF held off by a full queue.
        cam_wr_en = 1'b1; cam_data = MARK_SOF;
        step();
        cam_wr_en = 1'b0;
        step();
        check("t5_grant_camera", 32'(active_src), 32'd0);
        exp_q.push_back(MARK_SOF);
        exp_q.push_back(17'h00500);
        cam_wr_en = 1'b1; cam_data = MARK_SOF;
        step();
        cam_data = 17'h00500;
        step();
        cam_wr_en = 1'b0; queue_full = 1'b1;
        for (int i = 0; i < 150 && camera_alive; i++) step();
        check("t5_watchdog_expired", 32'(camera_alive), 32'd0);
        exp_q.push_back(MARK_EOF);
        step();
        err = 0;
        for (int i = 0; i < 10; i++) begin
            if (queue_wr_en !== 1'b1 || queue_data !== MARK_EOF || frames_truncated !== 8'd1) err++;
            step();
        end
        check("t5_eof_held", 32'(err), 32'd0);
        queue_full = 1'b0;
        step();
        check("t5_frames_truncated", 32'(frames_truncated), 32'd2);
        check("t5_single_eof", 32'(queue_wr_en), 32'd0);

        // Reset pulse mid-frame.
        step();
        check("t6_grant_pattern", 32'(active_src), 32'd1);
        exp_q.push_back(MARK_SOF);
        exp_q.push_back(MARK_SOL);
        exp_q.push_back(17'h00600);
        pat_wr_en = 1'b1;
        pat_data = MARK_SOF;  step();
        pat_data = MARK_SOL;  step();
        pat_data = 17'h00600; step();
        pat_wr_en = 1'b0; reset = 1'b1;
        step();
        check("t6_rst_active_src", 32'(active_src), 32'd0);
        check("t6_rst_frames_done", 32'(frames_done), 32'd0);
        check("t6_rst_frames_truncated", 32'(frames_truncated), 32'd0);
        check("t6_rst_camera_alive", 32'(camera_alive), 32'd0);
        check("t6_rst_queue_wr_en", 32'(queue_wr_en), 32'd0);
        check("t6_rst_queue_data", 32'(queue_data), 32'd0);
        reset = 1'b0;
        step();
        check("t6_auto_grant_pattern", 32'(active_src), 32'd1);
        repeat (3) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/frame_source_arbiter.md
# frame_source_arbiter

Arbitrates the single 17-bit frame queue between two word-stream producers: the camera capture path (source 0) and the debug pattern generator (source 1). Grants the queue to one source at a time and switches only on frame boundaries, so downstream display logic always sees whole frames. An internal camera watchdog can fall back to the pattern automatically and inject a frame-end marker when the camera stalls mid-frame. Sits between both producers and the queue write port.

## Interface
- `WATCHDOG_CYCLES`, 1_000_000: cycles without a camera frame-start before the camera is declared dead.
- `HOLD_MASK`, 2'b10: per-source bit. 1 = non-granted source sees full=1 and stalls; 0 = it sees full=0 and its words are discarded.

- `clk` in 1: sole clock; also drives `queue_wr_clk`.
- `reset` in 1: synchronous, active-high.
- `mode` in 2: 0 = camera forced, 1 = pattern forced, 2/3 = auto.
- `cam_data` in 17: camera word.
- `cam_wr_en` in 1: camera write strobe.
- `cam_full` out 1: back-pressure to the camera.
- `pat_data` in 17: pattern word.
- `pat_wr_en` in 1: pattern write strobe.
- `pat_full` out 1: back-pressure to the pattern generator.
- `queue_full` in 1: queue full.
- `queue_data` out 17: queue write data.
- `queue_wr_en` out 1: queue write strobe.
- `queue_wr_clk` out 1: equals `clk`.
- `active_src` out 1: current grant (0 = camera).
- `camera_alive` out 1: watchdog status.
- `frames_done` out 16: count of frames forwarded complete; wraps.
- `frames_truncated` out 8: count of injected frame-end markers; saturates at 255.

## Operation
- Markers (bit16=1):
  - SOF = 17'h10000
  - SOL = 17'h10001
  - EOF = 17'h1FFFF
- Pixel words have bit16=0.
- A word is accepted when `wr_en && !queue_full`.
- Desired source:
  - `mode` 0 → camera.
  - `mode` 1 → pattern.
  - Auto → camera if `camera_alive`, else pattern.
- Watchdog counter:
  - Cleared to 0 on any cycle with `cam_wr_en && cam_data==SOF`, granted or not.
  - Otherwise increments, saturating at `WATCHDOG_CYCLES`.
  - `camera_alive` = (count < `WATCHDOG_CYCLES`).
- States:
  - **WAIT_SOF**
    - If desired ≠ `active_src`: `active_src` ← desired; no forwarding that cycle.
    - Else granted words are discarded (`queue_wr_en`=0, granted full=0) until an accepted SOF. The SOF is forwarded and the state moves to IN_FRAME.
  - **IN_FRAME**
    - Granted stream is forwarded combinationally.
    - Accepted EOF → WAIT_SOF and `frames_done`+1.
    - A repeated SOF is forwarded; the state stays IN_FRAME.
    - If `active_src`=camera, mode is auto and `camera_alive`=0 → INJECT_EOF. No camera word is forwarded that cycle.
    - A desired-source change otherwise waits for EOF.
  - **INJECT_EOF**
    - Drives `queue_wr_en`=1 and `queue_data`=EOF. Camera words are dropped (`cam_full`=0).
    - When `!queue_full`: `frames_truncated`+1 and → WAIT_SOF.
- Back-pressure:
  - Granted source's full = `queue_full` in IN_FRAME, and 0 in WAIT_SOF discard.
  - Non-granted source's full = its `HOLD_MASK` bit.

## Timing
- Forwarding is a combinational mux from the registered `active_src`/state: zero latency from source to queue and from `queue_full` to source full.
- The grant switch costs exactly 1 cycle in WAIT_SOF.
- Reset values:
  - State WAIT_SOF, `active_src`=0.
  - Watchdog = `WATCHDOG_CYCLES`, so `camera_alive`=0.
  - Counters 0, `queue_wr_en`=0, `queue_data`=0.
- Consequence: in auto mode after reset, the grant moves to pattern 1 cycle after reset is released.
- Reset mid-frame aborts with no EOF injection. Downstream must tolerate a missing EOF after reset.
- A camera SOF in the same cycle the watchdog would expire: the clear wins and the camera stays alive.
- EOF accepted in the same cycle as a desired change: EOF is forwarded, and the grant changes on the next cycle.
- `queue_full` held during INJECT_EOF: remain in INJECT_EOF indefinitely with `queue_wr_en` held high.

## Structure
- Shared package `frame_queue_pkg` holds:
  - Marker constants `MARK_SOF`, `MARK_SOL`, `MARK_EOF`.
  - Enum `frame_src_t` {SRC_CAMERA, SRC_PATTERN}.
  - Enum `arb_mode_t`.
  - Enum `arb_state_t`.
- Sub-module `frame_watchdog` contains the saturating counter, SOF-detect clear and `alive` output. Parameter: `WATCHDOG_CYCLES`.
- The arbiter FSM, mux and counters stay in the top module.

## Test plan
- **Forced pattern:** `mode`=1, pattern emits SOF, SOL, 480 pixels, EOF with `queue_full`=0 → all 483 words forwarded unchanged, `frames_done`=1, `cam_full`=0 throughout.
- **Auto, camera live:** `WATCHDOG_CYCLES`=100, auto mode, pattern mid-frame; camera SOF every 50 cycles → pattern frame completes through EOF, 1 idle cycle, then camera words are discarded until the next camera SOF, which is forwarded. `active_src`=0 from then on.
- **Camera stall:** granted camera in IN_FRAME stops writing for 100 cycles → INJECT_EOF emits 17'h1FFFF, `frames_truncated`=1, grant moves to pattern, and the next forwarded word is the pattern SOF.
- **Back-pressure:** `queue_full`=1 for 20 cycles mid-frame → `pat_full`=1, no word is lost or duplicated, and the word count at EOF is exact.
- **INJECT_EOF held off:** `queue_full` asserted while in INJECT_EOF → EOF is held until full drops, with exactly one EOF written.
- **Reset mid-frame:** `reset` pulsed for 1 cycle during IN_FRAME → outputs return to reset values next cycle, and `active_src`=1 one cycle after release in auto mode.
